// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a big-endian byte stream into 32-bit instruction
// words and writes them sequentially into instruction memory starting at
// word address 0. Loading stops on HALT_WORD (which is itself written) or
// when the top address has been written, after which done is held.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             1-cycle pulse, begins a load (ignored while busy)
//   rx_data/rx_valid  byte stream, one strobe per byte
//   mem_we/addr/wdata instruction-memory write port, one cycle per word
//   busy              high while loading or writing
//   done              high once loading has ended, until start or reset
//   overflow          load ended by full memory without HALT_WORD
//   word_count        words written in the current or last load
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CNT_MAX  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [1:0]        byte_cnt, byte_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       word_d;
  logic [ADDR_W:0]   cnt_d;
  logic              ovf_d;

  // State and datapath registers; status outputs are registered from next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= 2'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      word_count <= '0;
      overflow   <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      byte_cnt   <= byte_cnt_d;
      mem_addr   <= addr_d;
      mem_wdata  <= word_d;
      word_count <= cnt_d;
      overflow   <= ovf_d;
      mem_we     <= (state_d == WRITE);
      busy       <= (state_d == LOAD) || (state_d == WRITE);
      done       <= (state_d == DONE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    addr_d     = mem_addr;
    word_d     = mem_wdata;
    cnt_d      = word_count;
    ovf_d      = overflow;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          byte_cnt_d = 2'd0;
          addr_d     = '0;
          word_d     = 32'd0;
          cnt_d      = '0;
          ovf_d      = 1'b0;
        end
      end
      LOAD: begin
        if (rx_valid) begin
          word_d     = {mem_wdata[23:0], rx_data};
          byte_cnt_d = byte_cnt + 2'd1;  // wraps to 0 on the 4th byte
          if (byte_cnt == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        if (word_count != CNT_MAX) cnt_d = word_count + (ADDR_W+1)'(1);
        if (mem_wdata == HALT_WORD) begin
          state_d = DONE;
          ovf_d   = 1'b0;
        end else if (mem_addr == ADDR_MAX) begin
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          state_d = LOAD;
          addr_d  = mem_addr + ADDR_W'(1);
          // A byte arriving alongside the write starts the next word
          if (rx_valid) begin
            word_d     = {mem_wdata[23:0], rx_data};
            byte_cnt_d = 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Testbench for instr_mem_loader: directed byte streams, expected writes
// queued per DUT and checked by independent monitors on the falling edge.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start2;
  logic [7:0]  rx_data, rx_data2;
  logic        rx_valid, rx_valid2;

  logic        mem_we, busy, done, overflow;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        mem_we2, busy2, done2, overflow2;
  logic [1:0]  mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0]  word_count2;

  int checks = 0;
  int failures = 0;
  int we_pulses = 0;
  logic prev_we = 1'b0, prev_we2 = 1'b0;

  logic [39:0] exp_q[$];
  logic [33:0] exp_q2[$];

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .overflow(overflow), .word_count(word_count)
  );

  instr_mem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2),
    .done(done2), .overflow(overflow2), .word_count(word_count2)
  );

  // Monitor for the 8-bit-address instance
  always @(negedge clk) begin
    if (mem_we) begin
      logic [39:0] e;
      we_pulses++;
      checks++;
      if (prev_we) begin
        failures++;
        $display("FAIL we_width: mem_we high on consecutive cycles, required 1-cycle pulse");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          failures++;
          $display("FAIL write: got (%h,%h) required (%h,%h)", mem_addr, mem_wdata, e[39:32], e[31:0]);
        end
      end
    end
    prev_we = mem_we;
  end

  // Monitor for the 2-bit-address instance
  always @(negedge clk) begin
    if (mem_we2) begin
      logic [33:0] e;
      checks++;
      if (prev_we2) begin
        failures++;
        $display("FAIL we_width2: mem_we high on consecutive cycles, required 1-cycle pulse");
      end
      checks++;
      if (exp_q2.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write2: addr=%h data=%h, required no write", mem_addr2, mem_wdata2);
      end else begin
        e = exp_q2.pop_front();
        if ({mem_addr2, mem_wdata2} !== e) begin
          failures++;
          $display("FAIL write2: got (%h,%h) required (%h,%h)", mem_addr2, mem_wdata2, e[33:32], e[31:0]);
        end
      end
    end
    prev_we2 = mem_we2;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int which);
    if (which == 2) start2 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start2 = 1'b0;
  endtask

  // Send one byte; gap adds idle cycles afterwards
  task automatic send(input int which, input logic [7:0] b, input int gap);
    if (which == 2) begin rx_data2 = b; rx_valid2 = 1'b1; end
    else begin rx_data = b; rx_valid = 1'b1; end
    tick();
    rx_valid = 1'b0; rx_valid2 = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input int gap);
    for (int i = 3; i >= 0; i--) send(which, w[8*i +: 8], (i == 0) ? gap : 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_q2.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk(name, 64'(exp_q.size() + exp_q2.size()), 64'd0);
  endtask

  initial begin
    int p0;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    rx_data = 8'h00; rx_data2 = 8'h00; rx_valid = 1'b0; rx_valid2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_count", 64'(word_count), 0);

    // T6: bytes in IDLE without start are ignored
    send_word(1, 32'h12345678, 1);
    send_word(1, 32'hFFFFFFFF, 1);
    chk("t6_busy", 64'(busy), 0);
    chk("t6_count", 64'(word_count), 0);
    chk("t6_done", 64'(done), 0);

    // T1: gapped bytes, three words ending in HALT
    exp_q.push_back({8'd0, 32'h20080005});
    exp_q.push_back({8'd1, 32'h00000000});
    exp_q.push_back({8'd2, 32'hFFFFFFFF});
    pulse_start(1);
    chk("t1_busy", 64'(busy), 1);
    send_word(1, 32'h20080005, 1);
    send_word(1, 32'h00000000, 1);
    send_word(1, 32'hFFFFFFFF, 0);
    drain("t1_drain");
    tick();
    chk("t1_done", 64'(done), 1);
    chk("t1_busy_end", 64'(busy), 0);
    chk("t1_ovf", 64'(overflow), 0);
    chk("t1_count", 64'(word_count), 3);

    // T2: back-to-back bytes including during WRITE
    exp_q.push_back({8'd0, 32'h20080005});
    exp_q.push_back({8'd1, 32'h00000000});
    exp_q.push_back({8'd2, 32'hFFFFFFFF});
    pulse_start(1);
    chk("t2_done_clr", 64'(done), 0);
    p0 = we_pulses;
    send_word(1, 32'h20080005, 0);
    send_word(1, 32'h00000000, 0);
    send_word(1, 32'hFFFFFFFF, 0);
    drain("t2_drain");
    repeat (3) tick();
    chk("t2_pulses", 64'(we_pulses - p0), 3);
    chk("t2_done", 64'(done), 1);
    chk("t2_count", 64'(word_count), 3);

    // T3: 4-word memory fills without HALT
    for (int i = 0; i < 4; i++) exp_q2.push_back({2'(i), 32'(i + 1)});
    pulse_start(2);
    for (int i = 1; i <= 4; i++) send_word(2, 32'(i), 1);
    drain("t3_drain");
    chk("t3_done", 64'(done2), 1);
    chk("t3_ovf", 64'(overflow2), 1);
    chk("t3_count", 64'(word_count2), 4);
    chk("t3_busy", 64'(busy2), 0);
    send_word(2, 32'h00000005, 2);
    chk("t3_count_after", 64'(word_count2), 4);

    // T4: reset mid-load discards the partial word
    pulse_start(1);
    send(1, 8'hAA, 0);
    send(1, 8'hBB, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_we", 64'(mem_we), 0);
    chk("t4_wdata", 64'(mem_wdata), 0);
    chk("t4_busy", 64'(busy), 0);
    chk("t4_done2", 64'(done2), 0);
    exp_q.push_back({8'd0, 32'h11223344});
    exp_q.push_back({8'd1, 32'hFFFFFFFF});
    pulse_start(1);
    send_word(1, 32'h11223344, 0);
    send_word(1, 32'hFFFFFFFF, 0);
    drain("t4_drain");
    tick();
    chk("t4_count", 64'(word_count), 2);

    // T5: start while busy is ignored; restart from DONE
    exp_q.push_back({8'd0, 32'hCAFEBABE});
    exp_q.push_back({8'd1, 32'hFFFFFFFF});
    pulse_start(1);
    send(1, 8'hCA, 0);
    send(1, 8'hFE, 0);
    pulse_start(1);
    send(1, 8'hBA, 0);
    send(1, 8'hBE, 1);
    send_word(1, 32'hFFFFFFFF, 0);
    drain("t5_drain");
    tick();
    chk("t5_done", 64'(done), 1);
    chk("t5_count", 64'(word_count), 2);
    pulse_start(1);
    chk("t5_restart_done", 64'(done), 0);
    chk("t5_restart_busy", 64'(busy), 1);
    chk("t5_restart_count", 64'(word_count), 0);
    exp_q.push_back({8'd0, 32'h00000007});
    exp_q.push_back({8'd1, 32'hFFFFFFFF});
    send_word(1, 32'h00000007, 1);
    send_word(1, 32'hFFFFFFFF, 0);
    drain("t5_drain2");
    tick();
    chk("t5_count2", 64'(word_count), 2);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
